// File: rtl/mem_pkg.sv
// Shared load/store encodings, responder states and the lane merge/extend helpers
// used by both the data memory responder and the datapath's control decoder.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replace the addressed byte/half of old_word; a word store takes wdata whole.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/sram_sp.sv
// Single-port DEPTH x 32 RAM: synchronous read (data the cycle after the address),
// full-word write. Contents are not reset.
module sram_sp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side load/store responder: one request at a time against a word RAM,
// sub-word stores by read-modify-write, registered one-cycle response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           sgn_q, sgn_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;

    logic           accept, bad;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [31:0]    ram_rdata;

    assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // The read is launched from the live request address in the accept cycle,
    // so the word is already on ram_rdata during RD and can be registered.
    assign ram_addr = (state_q == ST_IDLE) ? bus.req_addr[AW+1:2] : addr_q[AW+1:2];
    assign ram_we   = (state_q == ST_WR) && !reset;

    sram_sp #(.DEPTH(DEPTH), .AW(AW)) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        accept       = bus.req_valid && bus.req_ready;
        bad          = bad_size_align(bus.req_size, bus.req_addr[1:0])
                       || (bus.req_addr[31:AW+2] != '0);
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.req_addr[AW+1:0];
                    wdata_d = bus.req_wdata;
                    if (bad) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = ST_RESP;
                    end else if (!bus.req_we || bus.req_size != SZ_WORD) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    wdata_d = merge_lanes(ram_rdata, wdata_q, size_q, addr_q[1:0]);
                    state_d = ST_WR;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extend_load(ram_rdata, size_q, addr_q[1:0], sgn_q);
                    state_d      = ST_RESP;
                end
            end
            ST_WR: begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
        we_q    <= we_d;
        size_q  <= size_d;
        sgn_q   <= sgn_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the datapath's load/store port: accepts one byte/half/word load or store request at a time, performs it against an internal single-port word RAM, and returns a one-cycle response with extended load data or an error flag. Sub-word stores (SB/SH) are done by read-modify-write, so latency depends on the operation. It sits between the datapath's MEM stage and the data array, replacing the purely combinational data memory.

## Interface
- DEPTH, 256: number of 32-bit words in the array (power of two).
- AW, 8: word-index width, log2(DEPTH).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; priority over all other inputs.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend (LB/LH), 0 = zero-extend.
- req_addr  in  32  byte address, little-endian lanes.
- req_wdata  in  32  store data; byte in [7:0], half in [15:0].
- resp_valid  out  1  one-cycle pulse, response present.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, reserved size, or out of range.

## Operation
- Request accepted when req_valid && req_ready; all req_* fields latched that cycle; later changes ignored.
- Error if: size 11; half with addr[0]≠0; word with addr[1:0]≠0; addr ≥ 4*DEPTH. Errored requests never touch the array.
- States: IDLE, RD, WR, RESP.
  - IDLE: req_ready=1. Accept → error ? RESP : (load or sub-word store) ? RD : WR (SW).
  - RD: array read of word addr[AW+1:2]. Load → RESP; SB/SH → WR.
  - WR: write word. SW writes req_wdata. SB replaces lane addr[1:0] with wdata[7:0]; SH replaces lane pair addr[1] with wdata[15:0]; other lanes unchanged from RD data. → RESP.
  - RESP: resp_valid=1 for exactly this cycle → IDLE.
- Load extraction: byte lane addr[1:0], half lanes addr[1]*2 +: 2, word whole; extend to 32 per req_signed (ignored for word).
- No response backpressure: the consumer must take resp_* in the RESP cycle.

## Timing
- Accept at edge T (cycle T = IDLE with handshake).
- LW/LH/LB: RD T+1, resp_valid T+2. SW: WR T+1, resp T+2. SB/SH: RD T+1, WR T+2, resp T+3. Error: resp T+1.
- Next accept earliest the cycle after RESP (req_ready high again in the cycle after resp_valid).
- A load issued after a store's resp sees the stored data (write completes before RESP).
- Reset values: state IDLE, req_ready 0 while reset high then 1 from the first cycle after, resp_valid 0, resp_rdata 0, resp_err 0. RAM contents are not cleared by reset.
- Reset mid-operation: in-flight request dropped with no response; reset asserted in a WR cycle suppresses that write.
- req_valid while not ready: ignored, not queued.

## Structure
- Shared package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane-merge and extend functions, so the datapath's control decoder uses identical encodings.
- One sub-module: sram_sp, single-port DEPTH×32 RAM, synchronous read (data valid the cycle after address), write-enable with full-word write. The responder holds the FSM, request register, merge and extend logic.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → store resp at T+2 err 0; load resp_rdata 0xDEADBEEF at T+2.
- SB 0x11 data 0x000000A5 over 0xDEADBEEF (resp T+3); LW 0x10 → 0xDEADA5EF; LB signed 0x11 → 0xFFFFFFA5; LB unsigned → 0x000000A5.
- SH 0x12 data 0x00008001; LH signed 0x12 → 0xFFFF8001, unsigned → 0x00008001; LW 0x10 → 0x8001A5EF.
- Errors: LW 0x13, LH 0x01, size 11, SW 4*DEPTH → resp_err 1 at T+1, resp_rdata 0; following LW shows memory unchanged.
- Reset asserted in the WR cycle of SW 0x20 data 0x12345678 (prior content 0) → no resp_valid, req_ready 1 after reset, LW 0x20 → 0x00000000.
- Back-to-back req_valid held high → accepts spaced by latency+1, exactly one resp_valid per accepted request, none for non-accepted cycles.
